// File: rtl/uart_pkg.sv
// uart_pkg
// Shared constants for the UART transmit and receive buffering logic.
//   DATA_W_DEF : default byte width of the UART datapath
//   ADDR_W_DEF : default FIFO address width (depth = 2**ADDR_W_DEF)
//   IDLE, WAIT : launch sequencer state encodings
// No ports; imported by the FIFO memory and the TX FIFO top.

package uart_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  // Kept as plain 1-bit constants so older blocks can compare against them directly.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem
// Register-array storage shared by the UART TX and RX FIFOs.
// Ports:
//   clk   : system clock, write happens on the rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
// Contents are not reset; the owning FIFO's pointers decide what is valid.

module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Transmit buffer and launch sequencer sitting in front of the UART transmitter.
// Bytes are queued in a circular FIFO; one at a time they are popped, presented
// on tx_din with a single-cycle tx_start, and the next launch waits for the
// transmitter's tx_done_tick.
// Ports:
//   clk          : system clock
//   reset        : asynchronous active-high reset
//   wr, w_data   : enqueue strobe and byte
//   full, empty  : FIFO status from the registered pointers
//   tx_start     : one-cycle launch pulse to the transmitter
//   tx_din       : byte being transmitted, held until the next launch
//   tx_done_tick : one-cycle completion pulse from the transmitter
//   busy         : sequencer waiting on the transmitter or bytes still queued
//   ovf          : sticky overflow flag
// Build option: define UART_TXF_OVF_EN to enable the sticky overflow flag;
// otherwise ovf is tied low.

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  output logic              full,
  output logic              empty,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_din,
  input  logic              tx_done_tick,
  output logic              busy,
  output logic              ovf
);

  // One extra pointer bit distinguishes full from empty when the addresses match.
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic [0:0]        state;
  logic              wr_en;
  logic              pop;
  logic [DATA_W-1:0] rd_data;

  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[ADDR_W] != rptr[ADDR_W]);
  assign wr_en = wr && !full;
  assign pop   = (state == IDLE) && !empty;
  assign busy  = (state != IDLE) || !empty;

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr[ADDR_W-1:0]),
    .wdata (w_data),
    .raddr (rptr[ADDR_W-1:0]),
    .rdata (rd_data)
  );

  // Write pointer advances only on accepted writes; full is judged before any
  // pop in the same cycle, so a simultaneous pop never frees the slot early.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
    end else if (wr_en) begin
      wptr <= wptr + 1'b1;
    end
  end

  // Launch sequencer: from IDLE with data waiting, latch the head byte, pulse
  // tx_start and pop; then sit in WAIT until the transmitter reports done.
  // tx_start defaults low every edge so it can only ever last one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rptr     <= '0;
      tx_start <= 1'b0;
      tx_din   <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_din   <= rd_data;
            tx_start <= 1'b1;
            rptr     <= rptr + 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (tx_done_tick) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TXF_OVF_EN
  // Sticky record that a write arrived while the FIFO was full; cleared only by reset.
  logic ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (wr && full) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Directed self-checking bench for uart_tx_fifo. Inputs change on the falling
// clock edge; outputs are read on the falling edge, and a monitor records every
// cycle in which tx_start is high (sampled 1 time unit after the rising edge).

module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic       tx_done_tick = 1'b0;
  logic       full;
  logic       empty;
  logic       tx_start;
  logic [7:0] tx_din;
  logic       busy;
  logic       ovf;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] launch_q[$];

`ifdef UART_TXF_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .w_data       (w_data),
    .full         (full),
    .empty        (empty),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .ovf          (ovf)
  );

  // Record of every launch: a stuck or doubled tx_start shows up as extra entries.
  always @(posedge clk) begin
    #1;
    if (tx_start === 1'b1) launch_q.push_back(tx_din);
  end

  function automatic logic [7:0] q_at(input int i);
    if (i < launch_q.size()) return launch_q[i];
    return 8'hxx;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    wr = 1'b1;
    w_data = b;
  endtask

  task automatic idle_wr;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic send_done;
    @(negedge clk);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({tx_start, empty, full, busy, ovf} !== 5'b01000) begin
      $display("[TB] FAIL reset_flags: got start/empty/full/busy/ovf=%b required 01000", {tx_start, empty, full, busy, ovf});
      miscompares++;
    end
    vectors++;
    if (tx_din !== 8'h00) begin
      $display("[TB] FAIL reset_tx_din: got %h required 00", tx_din);
      miscompares++;
    end
    reset = 1'b0;
  endtask

  task automatic test_single_byte;
    launch_q.delete();
    push_byte(8'hA5);
    idle_wr();
    vectors++;
    if (empty !== 1'b0 || launch_q.size() != 0) begin
      $display("[TB] FAIL single_after_write: got empty=%b launches=%0d required empty=0 launches=0", empty, launch_q.size());
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (tx_start !== 1'b1 || tx_din !== 8'hA5 || busy !== 1'b1) begin
      $display("[TB] FAIL single_launch: got start=%b din=%h busy=%b required start=1 din=a5 busy=1", tx_start, tx_din, busy);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (tx_start !== 1'b0 || busy !== 1'b1 || launch_q.size() != 1) begin
      $display("[TB] FAIL single_pulse_width: got start=%b busy=%b launches=%0d required 0 1 1", tx_start, busy, launch_q.size());
      miscompares++;
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      $display("[TB] FAIL single_busy_hold: got %b required 1", busy);
      miscompares++;
    end
    send_done();
    vectors++;
    if (busy !== 1'b0 || empty !== 1'b1 || tx_din !== 8'hA5) begin
      $display("[TB] FAIL single_done: got busy=%b empty=%b din=%h required 0 1 a5", busy, empty, tx_din);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back;
    launch_q.delete();
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    idle_wr();
    repeat (3) @(negedge clk);
    vectors++;
    if (launch_q.size() != 1 || q_at(0) !== 8'h01) begin
      $display("[TB] FAIL burst_first: got launches=%0d byte=%h required 1 01", launch_q.size(), q_at(0));
      miscompares++;
    end
    for (int k = 1; k <= 2; k++) begin
      send_done();
      vectors++;
      if (launch_q.size() != k) begin
        $display("[TB] FAIL burst_gap%0d: got launches=%0d required %0d", k, launch_q.size(), k);
        miscompares++;
      end
      @(negedge clk);
      vectors++;
      if (launch_q.size() != k + 1 || q_at(k) !== 8'(k + 1)) begin
        $display("[TB] FAIL burst_next%0d: got launches=%0d byte=%h required %0d %h", k, launch_q.size(), q_at(k), k + 1, 8'(k + 1));
        miscompares++;
      end
    end
    send_done();
    repeat (2) @(negedge clk);
    vectors++;
    if (empty !== 1'b1 || busy !== 1'b0 || launch_q.size() != 3) begin
      $display("[TB] FAIL burst_end: got empty=%b busy=%b launches=%0d required 1 0 3", empty, busy, launch_q.size());
      miscompares++;
    end
  endtask

  task automatic test_full;
    logic [7:0] exp;
    launch_q.delete();
    push_byte(8'h0F);
    idle_wr();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 15) begin
        vectors++;
        if (full !== 1'b0) begin
          $display("[TB] FAIL full_at_15: got %b required 0", full);
          miscompares++;
        end
      end
      wr = 1'b1;
      w_data = 8'h10 + 8'(i);
    end
    @(negedge clk);
    vectors++;
    if (full !== 1'b1 || empty !== 1'b0 || ovf !== 1'b0) begin
      $display("[TB] FAIL full_at_16: got full=%b empty=%b ovf=%b required 1 0 0", full, empty, ovf);
      miscompares++;
    end
    w_data = 8'hEE;
    @(negedge clk);
    wr = 1'b0;
    vectors++;
    if (full !== 1'b1 || ovf !== EXP_OVF) begin
      $display("[TB] FAIL full_overflow: got full=%b ovf=%b required 1 %b", full, ovf, EXP_OVF);
      miscompares++;
    end
    for (int j = 0; j < 17; j++) begin
      send_done();
      @(negedge clk);
    end
    vectors++;
    if (launch_q.size() != 17) begin
      $display("[TB] FAIL full_drain_count: got %0d required 17", launch_q.size());
      miscompares++;
    end
    for (int j = 0; j < 17; j++) begin
      exp = (j == 0) ? 8'h0F : 8'h10 + 8'(j - 1);
      vectors++;
      if (q_at(j) !== exp) begin
        $display("[TB] FAIL full_drain_byte%0d: got %h required %h", j, q_at(j), exp);
        miscompares++;
      end
    end
    vectors++;
    if (empty !== 1'b1 || busy !== 1'b0 || ovf !== EXP_OVF) begin
      $display("[TB] FAIL full_after_drain: got empty=%b busy=%b ovf=%b required 1 0 %b", empty, busy, ovf, EXP_OVF);
      miscompares++;
    end
  endtask

  task automatic test_wrap;
    logic [7:0] exp;
    launch_q.delete();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) push_byte(8'(((r * 12 + i) * 7) % 256));
      idle_wr();
      repeat (2) @(negedge clk);
      for (int j = 0; j < 12; j++) begin
        send_done();
        @(negedge clk);
      end
    end
    vectors++;
    if (launch_q.size() != 36) begin
      $display("[TB] FAIL wrap_count: got %0d required 36", launch_q.size());
      miscompares++;
    end
    for (int n = 0; n < 36; n++) begin
      exp = 8'((n * 7) % 256);
      vectors++;
      if (q_at(n) !== exp) begin
        $display("[TB] FAIL wrap_byte%0d: got %h required %h", n, q_at(n), exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid;
    launch_q.delete();
    for (int i = 0; i < 5; i++) push_byte(8'h31 + 8'(i));
    idle_wr();
    @(negedge clk);
    vectors++;
    if (tx_din !== 8'h31 || empty !== 1'b0) begin
      $display("[TB] FAIL mid_before_reset: got din=%h empty=%b required 31 0", tx_din, empty);
      miscompares++;
    end
    #2 reset = 1'b1;
    launch_q.delete();
    #1;
    vectors++;
    if ({tx_start, empty, full, busy, ovf} !== 5'b01000 || tx_din !== 8'h00) begin
      $display("[TB] FAIL mid_async_reset: got start/empty/full/busy/ovf=%b din=%h required 01000 00", {tx_start, empty, full, busy, ovf}, tx_din);
      miscompares++;
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (launch_q.size() != 0 || empty !== 1'b1) begin
      $display("[TB] FAIL mid_discard: got launches=%0d empty=%b required 0 1", launch_q.size(), empty);
      miscompares++;
    end
    push_byte(8'h5A);
    idle_wr();
    repeat (2) @(negedge clk);
    vectors++;
    if (launch_q.size() != 1 || q_at(0) !== 8'h5A) begin
      $display("[TB] FAIL mid_relaunch: got launches=%0d byte=%h required 1 5a", launch_q.size(), q_at(0));
      miscompares++;
    end
    send_done();
  endtask

  task automatic test_stray_done;
    repeat (2) @(negedge clk);
    launch_q.delete();
    @(negedge clk);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (launch_q.size() != 0 || empty !== 1'b1 || busy !== 1'b0) begin
      $display("[TB] FAIL stray_no_launch: got launches=%0d empty=%b busy=%b required 0 1 0", launch_q.size(), empty, busy);
      miscompares++;
    end
    push_byte(8'h77);
    idle_wr();
    repeat (2) @(negedge clk);
    vectors++;
    if (launch_q.size() != 1 || q_at(0) !== 8'h77) begin
      $display("[TB] FAIL stray_next_byte: got launches=%0d byte=%h required 1 77", launch_q.size(), q_at(0));
      miscompares++;
    end
    send_done();
    repeat (3) @(negedge clk);
    vectors++;
    if (launch_q.size() != 1 || empty !== 1'b1 || busy !== 1'b0) begin
      $display("[TB] FAIL stray_settle: got launches=%0d empty=%b busy=%b required 1 1 0", launch_q.size(), empty, busy);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full();
    test_wrap();
    test_reset_mid();
    test_stray_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side buffer and launch sequencer placed directly upstream of the UART transmitter.
- Accepts bytes from the host or loopback logic into a circular FIFO.
- Pops one byte at a time and presents it to the transmitter with a one-cycle start pulse.
- Waits for the transmitter's done tick before launching the next byte.

Parameters:
- DATA_W, 8, width of each byte; matches the transmitter data input.
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W (16 entries).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr  input  1  write strobe; one byte per cycle.
- w_data  input  DATA_W  byte to enqueue, sampled when wr=1.
- full  output  1  FIFO holds 2**ADDR_W entries.
- empty  output  1  FIFO holds 0 entries.
- tx_start  output  1  one-cycle launch pulse to the transmitter.
- tx_din  output  DATA_W  byte for the transmitter; stable from the tx_start cycle until the next launch.
- tx_done_tick  input  1  one-cycle completion pulse from the transmitter.
- busy  output  1  high when state is not IDLE or the FIFO is not empty.
- ovf  output  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - read/write pointers = 0, state = IDLE.
  - tx_start = 0, tx_din = 0, ovf = 0.
  - empty = 1, full = 0, busy = 0.
  - Buffered bytes are discarded; memory contents need no reset.
- Pointers are ADDR_W+1 bits and wrap modulo 2**(ADDR_W+1).
  - empty = pointers equal.
  - full = address bits equal and MSBs differ.
  - full/empty are derived from the current registered pointers.
- Write: when wr=1 and full=0, w_data is stored at wptr and wptr increments at that edge.
  - wr while full: dropped, no pointer change.
  - A pop in the same cycle does not make room.
- FSM states: IDLE, WAIT.
  - IDLE and empty=0: at the next edge, tx_din <= mem[rptr], tx_start <= 1, rptr increments, state goes to WAIT.
  - tx_start is high for exactly one cycle; the register clears on the following edge.
  - WAIT: hold until tx_done_tick=1, then return to IDLE at that edge.
  - tx_done_tick is ignored in IDLE.
- Latency:
  - A write accepted at edge E0 into an empty FIFO in IDLE drives empty low after E0.
  - tx_start is high during the cycle after E1.
  - Back-to-back bytes: the done tick at edge Ed gives tx_start high after Ed+1, leaving one idle cycle between frames. The transmitter is back in idle by then.
- Simultaneous write and pop when not full and not empty: both take effect; the count is unchanged.
- A write to an empty FIFO cannot pop in the same cycle; the pop occurs on the following edge.

Optional Feature:
- Macro: UART_TXF_OVF_EN.
- Defined: ovf sets at the edge where wr=1 and full=1, stays set until reset, and does not affect FIFO operation.
- Undefined: ovf is tied to 0 and no overflow logic is synthesised.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state localparams (IDLE=1'b0, WAIT=1'b1).
  - Default DATA_W=8 and FIFO ADDR_W=4 constants, shared with the receive-side FIFO.
- One sub-module, uart_fifo_mem:
  - 2**ADDR_W x DATA_W register array.
  - Synchronous write port, combinational read port.
  - Reused by the RX FIFO.

Test Plan:
- Single byte: reset, write 0xA5 into an empty FIFO -> empty low the next cycle, one tx_start pulse with tx_din=0xA5 the cycle after, busy high until a tx_done_tick is supplied.
- Burst: write 0x01..0x03 on consecutive cycles while holding tx_done_tick low -> only one tx_start (tx_din=0x01); each done tick yields the next launch one idle cycle later, in order 0x01, 0x02, 0x03; then empty=1, busy=0.
- Full: write 16 bytes 0x10..0x1F with no done ticks -> full=1 after the 16th write accepting the un-popped remainder; a 17th write 0xEE is dropped. With UART_TXF_OVF_EN, ovf=1; without it, ovf=0. Drain -> 0xEE never appears.
- Wrap-around: three rounds of 12 writes and 12 drains (36 bytes, pattern i*7 mod 256) -> output sequence matches input exactly across the pointer wrap.
- Reset mid-operation: 5 bytes queued and WAIT state, assert reset -> tx_start=0, tx_din=0, empty=1, busy=0 immediately. After release, write 0x5A -> next launch carries 0x5A.
- Stray done: pulse tx_done_tick in IDLE with the FIFO empty -> no tx_start, no pointer change.
